// File: rtl/step_pkg.sv
// Shared types and constants for the step pulse generator.
package step_pkg;

    // Default width of step count, period, position and internal counters.
    localparam int CNT_W_DEFAULT = 16;

    // Move sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } step_state_t;

endpackage

// File: rtl/step_timer.sv
// Period timer for the step pulse generator.
// Counts clock cycles within one step period and raises a registered
// terminal-count flag during every cycle that is a multiple of the period.
module step_timer
    import step_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic             count,
    input  logic [CNT_W-1:0] period,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_W'(1);

    // cnt holds the index (1..period) of the current cycle within the period.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            cnt <= CNT_W'(1);
            tc  <= (period == CNT_W'(1));
        end else if (count) begin
            if (cnt == period) begin
                cnt <= CNT_W'(1);
                tc  <= (period == CNT_W'(1));
            end else begin
                cnt <= cnt_inc;
                tc  <= (cnt_inc == period);
            end
        end else begin
            cnt <= '0;
            tc  <= 1'b0;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Step pulse generator: issues STEPS one-cycle ENABLE pulses spaced PERIOD
// clocks apart, then a one-cycle DONE pulse. Direction and mode are latched
// at move acceptance and held until the next accepted move.
// Optional feature: define STEP_POS_TRACK_EN to track a signed half-step
// POSITION; otherwise POSITION is tied to zero.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             DIR_IN,
    input  logic             MODE_IN,
    input  logic [CNT_W-1:0] STEPS,
    input  logic [CNT_W-1:0] PERIOD,
    input  logic             ABORT,
    output logic             ENABLE,
    output logic             UP_DOWN,
    output logic             HALF_FULL,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] POSITION
);

    step_state_t      state;
    logic [CNT_W-1:0] steps_rem;
    logic [CNT_W-1:0] period_lat;
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] timer_period;
    logic             enable_tc;
    logic             accept;
    logic             last_step;
    logic             leave_run;
    logic             timer_load;
    logic             timer_count;

    // A zero period would never produce a pulse, so it runs at one clock per step.
    assign period_eff   = (PERIOD == '0) ? CNT_W'(1) : PERIOD;
    assign accept       = (state == IDLE) && START;
    assign last_step    = (state == RUN) && enable_tc && (steps_rem == CNT_W'(1));
    assign leave_run    = (state == RUN) && (ABORT || last_step);
    assign timer_load   = accept && (STEPS != '0);
    assign timer_count  = (state == RUN) && !leave_run;
    assign timer_period = timer_load ? period_eff : period_lat;

    step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (timer_load),
        .count  (timer_count),
        .period (timer_period),
        .tc     (enable_tc)
    );

    assign ENABLE = enable_tc;

    // Move sequencer with registered BUSY, DONE and latched direction/mode.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            steps_rem  <= '0;
            period_lat <= '0;
            UP_DOWN    <= 1'b0;
            HALF_FULL  <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        steps_rem  <= STEPS;
                        period_lat <= period_eff;
                        UP_DOWN    <= DIR_IN;
                        HALF_FULL  <= MODE_IN;
                        if (STEPS == '0) begin
                            state <= FINISH;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= RUN;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (enable_tc) begin
                        steps_rem <= steps_rem - CNT_W'(1);
                    end
                    if (leave_run) begin
                        state <= FINISH;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_POS_TRACK_EN
    logic [CNT_W-1:0] position_q;
    logic [CNT_W-1:0] pos_delta;

    // Signed half-step increment for one step in the latched direction and mode.
    always_comb begin
        pos_delta = CNT_W'(2);
        case ({UP_DOWN, HALF_FULL})
            2'b11:   pos_delta = CNT_W'(1);
            2'b10:   pos_delta = CNT_W'(2);
            2'b01:   pos_delta = '1;
            default: pos_delta = ~CNT_W'(1);
        endcase
    end

    // Position advances once per issued step pulse, wrapping modulo 2^CNT_W.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            position_q <= '0;
        end else if (enable_tc) begin
            position_q <= position_q + pos_delta;
        end
    end

    assign POSITION = position_q;
`else
    assign POSITION = '0;
`endif

endmodule
